// File: rtl/ldpc_pkg.sv
// Shared types and default code dimensions for the LDPC iteration controller
// and the datapath blocks that consume its addresses.
package ldpc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVnIssue,
    StVnDrain,
    StCnIssue,
    StCnDrain,
    StCheck,
    StOut
  } ldpc_state_e;

  localparam int unsigned DEF_N_COLS   = 8;
  localparam int unsigned DEF_N_ROWS   = 4;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_PIPE_LAT = 2;
  localparam int unsigned DEF_MAX_ITER = 20;
  localparam int unsigned DEF_ITER_W   = 8;
  localparam int unsigned MSG_WIDTH    = 16;
  // Wide enough for any drain depth up to 15.
  localparam int unsigned DRAIN_W      = 4;

endpackage

// File: rtl/ldpc_phase_cnt.sv
// Loadable up-counter with a terminal-count flag; used for both the column/row
// address and the pipeline-drain countdown.
module ldpc_phase_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Sequencer for the time-multiplexed LDPC decoder: LLR load, alternating VN/CN
// phases with pipeline drains, early termination, and hard-decision readout.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int unsigned N_COLS   = DEF_N_COLS,
  parameter int unsigned N_ROWS   = DEF_N_ROWS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  parameter int unsigned MAX_ITER = DEF_MAX_ITER,
  parameter int unsigned ITER_W   = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              llr_valid,
  output logic              llr_ready,
  output logic              llr_we,
  output logic              vn_en,
  output logic              cn_en,
  output logic              msg_clr,
  output logic [ADDR_W-1:0] addr,
  input  logic              par_valid,
  input  logic              par_fail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ADDR_W-1:0]  COL_LAST   = ADDR_W'(N_COLS - 1);
  localparam logic [ADDR_W-1:0]  ROW_LAST   = ADDR_W'(N_ROWS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);
  localparam logic [ITER_W-1:0]  ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam bit                 HAS_DRAIN  = (PIPE_LAT != 0);

  ldpc_state_e       state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              sticky_q, sticky_d;

  logic               addr_load, addr_inc, addr_tc;
  logic [ADDR_W-1:0]  addr_term;
  logic               drain_load, drain_inc, drain_tc;
  logic [DRAIN_W-1:0] drain_cnt;

  assign llr_we    = llr_valid & llr_ready;
  assign addr_term = (state_q == StCnIssue) ? ROW_LAST : COL_LAST;

  ldpc_phase_cnt #(
    .W(ADDR_W)
  ) u_addr_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (addr_load),
    .load_val('0),
    .inc     (addr_inc),
    .term    (addr_term),
    .cnt     (addr),
    .tc      (addr_tc)
  );

  ldpc_phase_cnt #(
    .W(DRAIN_W)
  ) u_drain_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (drain_load),
    .load_val('0),
    .inc     (drain_inc),
    .term    (DRAIN_LAST),
    .cnt     (drain_cnt),
    .tc      (drain_tc)
  );

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    conv_d     = conv_q;
    sticky_d   = sticky_q;
    addr_load  = 1'b0;
    addr_inc   = 1'b0;
    drain_load = 1'b0;
    drain_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          iter_d    = '0;
          conv_d    = 1'b0;
          addr_load = 1'b1;
        end
      end
      StLoad: begin
        if (llr_we) begin
          if (addr_tc) begin
            state_d   = StVnIssue;
            addr_load = 1'b1;
          end else begin
            addr_inc = 1'b1;
          end
        end
      end
      StVnIssue: begin
        if (addr_tc) begin
          addr_load = 1'b1;
          if (HAS_DRAIN) begin
            state_d    = StVnDrain;
            drain_load = 1'b1;
          end else begin
            state_d  = StCnIssue;
            sticky_d = 1'b0;
          end
        end else begin
          addr_inc = 1'b1;
        end
      end
      StVnDrain: begin
        if (drain_tc) begin
          state_d  = StCnIssue;
          sticky_d = 1'b0;
        end else begin
          drain_inc = 1'b1;
        end
      end
      StCnIssue: begin
        sticky_d = sticky_q | (par_valid & par_fail);
        if (addr_tc) begin
          addr_load = 1'b1;
          if (HAS_DRAIN) begin
            state_d    = StCnDrain;
            drain_load = 1'b1;
          end else begin
            state_d = StCheck;
          end
        end else begin
          addr_inc = 1'b1;
        end
      end
      StCnDrain: begin
        // Late parity results still in flight are folded in here.
        sticky_d = sticky_q | (par_valid & par_fail);
        if (drain_tc) begin
          state_d = StCheck;
        end else begin
          drain_inc = 1'b1;
        end
      end
      StCheck: begin
        iter_d    = iter_q + ITER_W'(1);
        addr_load = 1'b1;
        if (!sticky_q) begin
          state_d = StOut;
          conv_d  = 1'b1;
        end else if (iter_d == ITER_LIMIT) begin
          state_d = StOut;
          conv_d  = 1'b0;
        end else begin
          state_d = StVnIssue;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (addr_tc) begin
            state_d   = StIdle;
            addr_load = 1'b1;
          end else begin
            addr_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        addr_load = 1'b1;
      end
    endcase

    if (abort) begin
      state_d    = StIdle;
      iter_d     = iter_q;
      conv_d     = conv_q;
      addr_load  = 1'b1;
      addr_inc   = 1'b0;
      drain_load = 1'b0;
      drain_inc  = 1'b0;
    end
  end

  // Strobes are registered from the next state so they line up with addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      conv_q    <= 1'b0;
      sticky_q  <= 1'b0;
      llr_ready <= 1'b0;
      vn_en     <= 1'b0;
      cn_en     <= 1'b0;
      msg_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      conv_q    <= conv_d;
      sticky_q  <= sticky_d;
      llr_ready <= (state_d == StLoad);
      vn_en     <= (state_d == StVnIssue);
      cn_en     <= (state_d == StCnIssue);
      msg_clr   <= (state_d == StVnIssue) && (iter_d == '0);
      out_valid <= (state_d == StOut);
      busy      <= (state_d != StIdle);
    end
  end

  assign iter_count = iter_q;
  assign converged  = conv_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: one instance with MAX_ITER=3 and a
// lockstep twin with MAX_ITER=5 sharing all inputs.
module tb_ldpc_iter_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, llr_valid, out_ready, par_valid, par_fail;
  logic fail_en;

  logic       llr_ready, llr_we, vn_en, cn_en, msg_clr, out_valid, busy, converged;
  logic [7:0] addr, iter_count;
  logic       d5_llr_ready, d5_llr_we, d5_vn_en, d5_cn_en, d5_msg_clr;
  logic       d5_out_valid, d5_busy, d5_converged;
  logic [7:0] d5_addr, d5_iter_count;

  int errors = 0;
  int checks = 0;

  int n_vn = 0, n_cn = 0, n_clr = 0, n_we = 0, n_out = 0;
  int m_vn = 0, m_cn = 0, m_clr = 0, m_we = 0, m_out = 0;
  int b_vn, b_cn, b_clr, b_we, b_out, c_vn, c_cn, c_clr, c_we, c_out;

  always #5 clk = ~clk;

  // Row 2 fails when fail_en is set; VN-phase parity strobes are junk to be ignored.
  assign par_valid = cn_en | vn_en;
  assign par_fail  = vn_en | (fail_en & cn_en & (addr == 8'd2));

  ldpc_iter_ctrl #(
    .N_COLS(8), .N_ROWS(4), .ADDR_W(8), .PIPE_LAT(2), .MAX_ITER(3), .ITER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .llr_valid(llr_valid), .llr_ready(llr_ready), .llr_we(llr_we),
    .vn_en(vn_en), .cn_en(cn_en), .msg_clr(msg_clr), .addr(addr),
    .par_valid(par_valid), .par_fail(par_fail),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .converged(converged), .iter_count(iter_count)
  );

  ldpc_iter_ctrl #(
    .N_COLS(8), .N_ROWS(4), .ADDR_W(8), .PIPE_LAT(2), .MAX_ITER(5), .ITER_W(8)
  ) dut5 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .llr_valid(llr_valid), .llr_ready(d5_llr_ready), .llr_we(d5_llr_we),
    .vn_en(d5_vn_en), .cn_en(d5_cn_en), .msg_clr(d5_msg_clr), .addr(d5_addr),
    .par_valid(par_valid), .par_fail(par_fail),
    .out_valid(d5_out_valid), .out_ready(out_ready),
    .busy(d5_busy), .converged(d5_converged), .iter_count(d5_iter_count)
  );

  always @(negedge clk) begin
    if (vn_en) n_vn <= n_vn + 1;
    if (cn_en) n_cn <= n_cn + 1;
    if (msg_clr) n_clr <= n_clr + 1;
    if (llr_we) n_we <= n_we + 1;
    if (out_valid && out_ready) n_out <= n_out + 1;
    if (d5_vn_en) m_vn <= m_vn + 1;
    if (d5_cn_en) m_cn <= m_cn + 1;
    if (d5_msg_clr) m_clr <= m_clr + 1;
    if (d5_llr_we) m_we <= m_we + 1;
    if (d5_out_valid && out_ready) m_out <= m_out + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    b_vn = n_vn; b_cn = n_cn; b_clr = n_clr; b_we = n_we; b_out = n_out;
    c_vn = m_vn; c_cn = m_cn; c_clr = m_clr; c_we = m_we; c_out = m_out;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Eight back-to-back beats; returns in the first VN_ISSUE cycle.
  task automatic load_burst();
    llr_valid = 1'b1;
    ticks(8);
    llr_valid = 1'b0;
  endtask

  task automatic drain_out();
    out_ready = 1'b1;
    ticks(8);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; llr_valid = 1'b0; out_ready = 1'b0;
    fail_en = 1'b0;
    ticks(2);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_conv", converged, 0);
    chk("rst_vn_en", vn_en, 0);
    chk("rst_llr_ready", llr_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d5_busy", d5_busy, 0);
    rst = 1'b0;
    tick();

    // Nominal convergence in one iteration.
    snap();
    do_start();
    chk("load_ready", llr_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_addr", addr, 0);
    load_burst();                                   // cycle 1
    chk("vn_first_en", vn_en, 1);
    chk("vn_first_addr", addr, 0);
    chk("vn_first_clr", msg_clr, 1);
    ticks(7);                                       // cycle 8
    chk("vn_last_en", vn_en, 1);
    chk("vn_last_addr", addr, 7);
    tick();                                         // cycle 9
    chk("vdrain_vn", vn_en, 0);
    chk("vdrain_cn", cn_en, 0);
    ticks(2);                                       // cycle 11
    chk("cn_first_en", cn_en, 1);
    chk("cn_first_addr", addr, 0);
    ticks(3);                                       // cycle 14
    chk("cn_last_addr", addr, 3);
    ticks(3);                                       // cycle 17, CHECK
    chk("check_oval", out_valid, 0);
    chk("check_iter", iter_count, 0);
    chk("check_busy", busy, 1);
    tick();                                         // cycle 18
    chk("nom_oval", out_valid, 1);
    chk("nom_iter", iter_count, 1);
    chk("nom_conv", converged, 1);
    chk("nom_out_addr", addr, 0);
    drain_out();
    chk("nom_idle_busy", busy, 0);
    chk("nom_idle_oval", out_valid, 0);
    chk("nom_conv_hold", converged, 1);
    chk("nom_vn_cnt", n_vn - b_vn, 8);
    chk("nom_cn_cnt", n_cn - b_cn, 4);
    chk("nom_clr_cnt", n_clr - b_clr, 8);
    chk("nom_we_cnt", n_we - b_we, 8);
    chk("nom_out_cnt", n_out - b_out, 8);

    // Max-iteration exit with LLR and output backpressure.
    snap();
    fail_en = 1'b1;
    do_start();
    chk("mi_conv_clr", converged, 0);
    chk("mi_iter_clr", iter_count, 0);
    for (int i = 0; i < 8; i++) begin
      llr_valid = 1'b0;
      tick();
      chk("bp_addr_hold", addr, i);
      chk("bp_we_low", llr_we, 0);
      llr_valid = 1'b1;
      tick();
    end
    llr_valid = 1'b0;                               // cycle 1
    chk("bp_vn_start", vn_en, 1);
    ticks(50);                                      // cycle 51
    chk("mi_check_oval", out_valid, 0);
    chk("mi_check_iter", iter_count, 2);
    tick();                                         // cycle 52
    chk("mi_oval", out_valid, 1);
    chk("mi_iter", iter_count, 3);
    chk("mi_conv", converged, 0);
    chk("mi_vn_cnt", n_vn - b_vn, 24);
    chk("mi_cn_cnt", n_cn - b_cn, 12);
    chk("mi_clr_cnt", n_clr - b_clr, 8);
    chk("mi_we_cnt", n_we - b_we, 8);
    chk("mi_d5_busy", d5_busy, 1);
    out_ready = 1'b1;
    ticks(5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("obp_addr_hold", addr, 5);
      chk("obp_oval_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    ticks(3);
    out_ready = 1'b0;
    chk("mi_idle_busy", busy, 0);
    chk("mi_out_cnt", n_out - b_out, 8);
    fail_en = 1'b0;
    abort = 1'b1;                                   // twin is mid iteration 4
    tick();
    abort = 1'b0;
    chk("ab_d5_busy", d5_busy, 0);
    chk("ab_d5_iter", d5_iter_count, 3);
    chk("ab_idle_iter", iter_count, 3);

    // Late convergence on iteration 3.
    snap();
    do_start();
    load_burst();                                   // cycle 1
    fail_en = 1'b1;
    ticks(34);                                      // cycle 35
    fail_en = 1'b0;
    ticks(16);                                      // cycle 51
    chk("lc_check_oval", out_valid, 0);
    tick();                                         // cycle 52
    chk("lc_oval", out_valid, 1);
    chk("lc_conv", converged, 1);
    chk("lc_iter", iter_count, 3);
    chk("lc_d5_oval", d5_out_valid, 1);
    chk("lc_d5_conv", d5_converged, 1);
    chk("lc_d5_iter", d5_iter_count, 3);
    chk("lc_d5_addr", d5_addr, 0);
    chk("lc_d5_ready", d5_llr_ready, 0);
    drain_out();
    chk("lc_d5_idle", d5_busy, 0);
    chk("lc_d5_vn_cnt", m_vn - c_vn, 24);
    chk("lc_d5_cn_cnt", m_cn - c_cn, 12);
    chk("lc_d5_clr_cnt", m_clr - c_clr, 8);
    chk("lc_d5_we_cnt", m_we - c_we, 8);
    chk("lc_d5_out_cnt", m_out - c_out, 8);

    // Abort mid CN_ISSUE of iteration 2, then a clean frame.
    do_start();
    load_burst();                                   // cycle 1
    fail_en = 1'b1;
    ticks(29);                                      // cycle 30
    chk("pre_ab_cn", cn_en, 1);
    chk("pre_ab_addr", addr, 2);
    chk("pre_ab_iter", iter_count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    fail_en = 1'b0;
    chk("ab_cn_en", cn_en, 0);
    chk("ab_busy", busy, 0);
    chk("ab_addr", addr, 0);
    chk("ab_iter_keep", iter_count, 1);
    tick();
    chk("ab_stay_idle", busy, 0);
    do_start();
    chk("re_iter", iter_count, 0);
    chk("re_ready", llr_ready, 1);
    load_burst();
    ticks(17);                                      // cycle 18
    chk("re_oval", out_valid, 1);
    chk("re_conv", converged, 1);
    chk("re_iter_done", iter_count, 1);
    drain_out();
    chk("re_idle", busy, 0);

    // Start while busy is ignored; async reset mid VN_ISSUE.
    do_start();
    load_burst();                                   // cycle 1
    fail_en = 1'b1;
    ticks(19);                                      // cycle 20, iter 2 addr 2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_addr", addr, 3);
    chk("sb_vn_en", vn_en, 1);
    chk("sb_iter", iter_count, 1);
    chk("sb_ready", llr_ready, 0);
    chk("sb_clr", msg_clr, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vn_en", vn_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", addr, 0);
    chk("ar_iter", iter_count, 0);
    rst = 1'b0;
    fail_en = 1'b0;
    tick();
    chk("ar_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
